// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants, stage-count helper and stage record for pipelined_cla_adder.
// No ports. Imported by the interface, cla_segment and the top.
package pipelined_cla_pkg;

  localparam int SEG_W_DEF = 16;
  localparam int WIDTH_DEF = 64;

  // Stage count; 0 marks an illegal configuration so the top can reject it.
  function automatic int nseg(input int width, input int seg_w);
    return (seg_w > 0) ? width / seg_w : 0;
  endfunction

  // Stage record at the default width. The top declares the same layout
  // sized by its own WIDTH parameter.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [WIDTH_DEF-1:0] sum;
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
  } stage_def_t;

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result bus of pipelined_cla_adder.
//   slave  : the adder (takes in_valid/a/b/c_in/out_ready, drives in_ready and results)
//   master : operand issuer + result consumer
// Signals: in_valid, in_ready, a, b, c_in, [sub], out_valid, out_ready, sum, c_out, ovf.
// Macro PIPELINED_CLA_ADDER_SUB_EN adds the 1-bit sub signal.
interface pipelined_cla_adder_if import pipelined_cla_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef PIPELINED_CLA_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport slave (
`ifdef PIPELINED_CLA_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );

  modport master (
`ifdef PIPELINED_CLA_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder_cla_segment.sv
// cla_segment: combinational SEG_W-bit carry-lookahead adder.
//   a_i, b_i : segment operands      ci_i : carry in
//   s_o      : segment sum           co_o : carry out of the segment MSB
//   cm_o     : carry into the segment MSB (signed overflow = co_o ^ cm_o)
module cla_segment import pipelined_cla_pkg::*; #(
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             ci_i,
  output logic [SEG_W-1:0] s_o,
  output logic             co_o,
  output logic             cm_o
);
  logic [SEG_W-1:0] g, p;
  logic [SEG_W:0]   c;
  logic             acc, pp;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]ci,
  // expanded per bit so no carry depends on a lower carry.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b0;
    c[0] = ci_i;
    for (int i = 0; i < SEG_W; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & ci_i);
    end
  end

  assign s_o  = p ^ c[SEG_W-1:0];
  assign co_o = c[SEG_W];
  assign cm_o = c[SEG_W-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder resolving one SEG_W-bit segment per
// pipeline stage; latency NSEG = WIDTH/SEG_W cycles, one result per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pipelined_cla_adder_if.slave (valid/ready operands in, results out)
// Macro PIPELINED_CLA_ADDER_SUB_EN: adds bus.sub, computing A - B - !c_in.
module pipelined_cla_adder import pipelined_cla_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG_W = SEG_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int NSEG = nseg(WIDTH, SEG_W);

  if (SEG_W < 1 || NSEG < 1 || (WIDTH % SEG_W) != 0) begin : g_param_err
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of SEG_W");
  end

  // Stage k: carry into segment k, sum segments 0..k-1, operands (only
  // segments k.. still matter).
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t                        stg_q [NSEG];
  stage_t                        stg_d [NSEG];
  logic [NSEG:0]                 rdy;
  logic [NSEG-1:0][SEG_W-1:0]    seg_s;
  logic [NSEG-1:0]               seg_co;
  logic                          seg_cm [NSEG];
  logic                          sub;
  logic                          out_v;
  logic [WIDTH-1:0]              sum_full;

`ifdef PIPELINED_CLA_ADDER_SUB_EN
  assign sub = bus.sub;
`else
  assign sub = 1'b0;
`endif

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    cla_segment #(.SEG_W(SEG_W)) u_seg (
      .a_i  (stg_q[k].a[k*SEG_W +: SEG_W]),
      .b_i  (stg_q[k].b[k*SEG_W +: SEG_W]),
      .ci_i (stg_q[k].carry),
      .s_o  (seg_s[k]),
      .co_o (seg_co[k]),
      .cm_o (seg_cm[k])
    );
  end

  // Ready chain, evaluated from the output back; an empty stage is always
  // ready, which lets bubbles collapse behind a stalled output.
  always_comb begin
    rdy       = '0;
    rdy[NSEG] = bus.out_ready;
    for (int k = NSEG - 1; k >= 0; k--)
      rdy[k] = !stg_q[k].valid || rdy[k+1];
  end

  always_comb begin
    stg_d[0]       = '0;
    stg_d[0].valid = bus.in_valid;
    // Subtract is A + ~B + c_in: c_in=1 means "no borrow in".
    stg_d[0].carry = bus.c_in;
    stg_d[0].a     = bus.a;
    stg_d[0].b     = sub ? ~bus.b : bus.b;
    for (int k = 1; k < NSEG; k++) begin
      stg_d[k]       = stg_q[k-1];
      stg_d[k].carry = seg_co[k-1];
      stg_d[k].sum[(k-1)*SEG_W +: SEG_W] = seg_s[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) stg_q[k] <= '0;
    end else begin
      for (int k = 0; k < NSEG; k++)
        if (rdy[k]) stg_q[k] <= stg_d[k];
    end
  end

  // Final stage resolves the MSB segment combinationally.
  always_comb begin
    sum_full = stg_q[NSEG-1].sum;
    sum_full[(NSEG-1)*SEG_W +: SEG_W] = seg_s[NSEG-1];
  end

  // Results are forced to zero while nothing is presented, so an idle or
  // freshly reset adder shows all-zero outputs.
  assign out_v         = stg_q[NSEG-1].valid;
  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = out_v;
  assign bus.sum       = out_v ? sum_full : '0;
  assign bus.c_out     = out_v & seg_co[NSEG-1];
  assign bus.ovf       = out_v & (seg_co[NSEG-1] ^ seg_cm[NSEG-1]);
endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;
  localparam int W = 64;

  logic clk, rst, sub_drv;

  pipelined_cla_adder_if #(.WIDTH(W)) bus ();
  pipelined_cla_adder #(.WIDTH(W), .SEG_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef PIPELINED_CLA_ADDER_SUB_EN
  assign bus.sub = sub_drv;
`endif

  int total = 0, bad = 0, cyc = 0, n_in = 0, sb_t = 0;
  bit chk_lat = 0, stall_prev = 0, rdone = 0;
  logic [65:0] exp_q [$];
  int          tin_q [$];
  logic [65:0] held, sb_e;

  initial begin clk = 0; forever #5 clk = ~clk; end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Reference: plain 65-bit arithmetic; {ovf, c_out, sum}.
  function automatic logic [65:0] model(input logic [63:0] av, bv, input logic ci, sb);
    logic [63:0] bb;
    logic [64:0] full;
    logic        ov;
    bb   = sb ? ~bv : bv;
    full = {1'b0, av} + {1'b0, bb} + {64'd0, ci};
    ov   = (av[63] == bb[63]) && (full[63] != av[63]);
    return {ov, full};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0: return 64'hFFFF_FFFF_FFFF_FFFF;
      1: return 64'h0;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h0000_FFFF_FFFF_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic rsub();
`ifdef PIPELINED_CLA_ADDER_SUB_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard: every output transfer must match the oldest accepted input.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete(); tin_q.delete(); stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_hold", {bus.ovf, bus.c_out, bus.sum}, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_out: out_valid=1 with nothing in flight, sum=%h", bus.sum);
        end else begin
          sb_e = exp_q.pop_front();
          sb_t = tin_q.pop_front();
          chk("result", {bus.ovf, bus.c_out, bus.sum}, sb_e);
          if (chk_lat) chk("latency", cyc - sb_t, 4);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = {bus.ovf, bus.c_out, bus.sum};
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.c_in, sub_drv));
        tin_q.push_back(cyc);
        n_in++;
      end
    end
  end

  task automatic drive(input logic [63:0] av, bv, input logic ci, sb);
    int i;
    bus.in_valid = 1; bus.a = av; bus.b = bv; bus.c_in = ci; sub_drv = sb;
    i = 0;
    do begin @(negedge clk); i++; end while (!bus.in_ready && i < 200);
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", i);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_lit(input string nm, input logic [63:0] av, bv, input logic ci, sb,
                         input logic [63:0] es, input logic eco, eov);
    int n;
    drive(av, bv, ci, sb);
    bus.in_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 20);
    chk({nm, "_lat"}, n, 4);
    chk({nm, "_sum"}, bus.sum, es);
    chk({nm, "_cout"}, bus.c_out, eco);
    chk({nm, "_ovf"}, bus.ovf, eov);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    rst = 1; sub_drv = 0;
    bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.c_in = 0; bus.out_ready = 1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.c_out, 0);
    chk("rst_ovf", bus.ovf, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Pin the model against hand-computed values
    chk("model_ripple", model(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0), {2'b01, 64'h0});
    chk("model_ovf", model(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 0), {2'b10, 64'h8000_0000_0000_0000});
    chk("model_sub", model(64'd5, 64'd7, 1, 1), {2'b00, 64'hFFFF_FFFF_FFFF_FFFE});

    // Directed boundary cases through the DUT
    chk_lat = 1;
    run_lit("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0, 64'h0, 1, 0);
    run_lit("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 64'h8000_0000_0000_0000, 0, 1);
    run_lit("negovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 64'h0, 1, 1);
`ifdef PIPELINED_CLA_ADDER_SUB_EN
    run_lit("sub", 64'd5, 64'd7, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
`endif

    // Streaming: 100 back-to-back with out_ready held high
    for (int i = 0; i < 100; i++) drive(rnd64(), rnd64(), 1'($urandom_range(0, 1)), rsub());
    bus.in_valid = 0;
    drain();
    chk_lat = 0;

    // Backpressure from empty: 4 accepted, then stall; no bubble on release
    bus.out_ready = 0;
    n0 = n_in;
    fork
      begin
        for (int i = 0; i < 20; i++) drive(rnd64(), rnd64(), 1'($urandom_range(0, 1)), rsub());
        bus.in_valid = 0;
      end
      begin
        repeat (10) @(negedge clk);
        chk("bp_accepted", n_in - n0, 4);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        @(posedge clk); #1 bus.out_ready = 1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("bp_no_bubble", bus.out_valid, 1);
        end
      end
    join
    drain();

    // Random gaps on both sides
    rdone = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          end
          drive(rnd64(), rnd64(), 1'($urandom_range(0, 1)), rsub());
        end
        bus.in_valid = 0;
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.out_ready = 1;
      end
    join
    drain();

    // Reset mid-flight: 3 in flight, none completed
    for (int i = 0; i < 3; i++) drive(rnd64(), rnd64(), 1, 0);
    bus.in_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("rmid_valid_in_rst", bus.out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rmid_out_valid", bus.out_valid, 0);
      chk("rmid_outputs", {bus.ovf, bus.c_out, bus.sum}, 0);
      chk("rmid_in_ready", bus.in_ready, 1);
    end
    @(posedge clk); #1;

    // Recovery after reset
    chk_lat = 1;
    run_lit("post_rst", 64'h0000_0000_FFFF_FFFF, 64'h1, 0, 0, 64'h0000_0001_0000_0000, 0, 0);
    drain();
    chk("final_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
